shift_unit_pipe: RTL and testbench
==================================

Name: shift_unit_pipe

Overview:
- Parametrised, pipelined barrel shifter for the datapath. Successor to the fixed registered shift-left-by-2 used for branch offsets.
- Supports variable shift amount and four modes: SLL, SRL, SRA, ROTR.
- Shift work is split across STAGES register stages, with valid/ready flow control on both sides.
- Serves the ALU shift path and branch/jump offset generation; a branch offset is SLL with shamt 2.

Parameters:
- WIDTH, 32, data width in bits. Power of two, at least 4.
- STAGES, 2, pipeline register stages, range 1..$clog2(WIDTH). Sets latency.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  $clog2(WIDTH)  shift amount, unsigned.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: all stage valid bits 0, all stage data/shamt/op registers 0, so out_valid=0 and out_data=0. in_ready=1 while reset is deasserted and the pipe is empty.
- Shift split:
  - SHW = $clog2(WIDTH); BPS = ceil(SHW/STAGES).
  - Stage s (0..STAGES-1) applies shamt bits [s*BPS, min((s+1)*BPS, SHW)-1], in the selected mode, to the data from the previous stage.
  - Stage 0 takes in_data, in_shamt and in_op; later stages carry their own registered shamt/op.
  - Composition of partial shifts must equal a single shift by the full shamt for all four modes.
- Mode rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the original bit WIDTH-1, carried through the stages.
  - ROTR wraps the bits shifted out of bit 0 into bit WIDTH-1.
  - shamt=0 passes data through unchanged in every mode.
- Flow control: single global advance signal.
  - advance = out_ready OR NOT out_valid.
  - in_ready = advance, combinational; no combinational path from in_valid to in_ready.
  - On a clk edge with advance=1, every stage register loads from its predecessor and stage 0 valid loads in_valid. A beat is accepted iff in_valid AND in_ready.
  - On a clk edge with advance=0, all stage registers hold. out_data and out_valid stay stable until out_ready is high.
- Latency: a beat accepted at edge N appears at out_valid/out_data after edge N+STAGES-1 (STAGES edges including the accepting edge), provided advance stays 1.
- Throughput: one beat per cycle with out_ready held high.
- Bubbles: invalid slots advance with the pipe and are not collapsed.
- Ordering: results leave in acceptance order. No beat is lost or duplicated under any out_ready pattern.
- Reset mid-operation: asserting reset clears all valid bits and data registers immediately, without waiting for clk. In-flight beats are discarded. The first accept is permitted on the first clk edge after deassertion.
- Simultaneous events: out_ready=1 with the pipe full and in_valid=1 completes the output and accepts the input on the same edge.

Test Plan (WIDTH=32, STAGES=2, out_ready=1 unless stated):
- Reset: assert reset mid-cycle with beats in flight -> out_valid=0 and out_data=0x00000000 immediately, before the next clk edge. in_ready=1 after deassertion.
- Offset path: SLL 0xFFFFFFFF shamt 2 accepted at edge N -> out_valid=1, out_data=0xFFFFFFFC after edge N+1. SLL 0x00000001 shamt 31 -> 0x80000000.
- Right shifts: 0x80000000 shamt 31 -> SRL 0x00000001, SRA 0xFFFFFFFF. 0x7FFFFFF0 SRA shamt 4 -> 0x07FFFFFF.
- Rotate and zero shift: ROTR 0x12345678 shamt 8 -> 0x78123456. ROTR shamt 0 and SLL shamt 0 -> 0x12345678.
- Backpressure: issue 4 back-to-back beats (SLL 1 by 0,1,2,3) with out_ready=0 for 3 cycles -> in_ready=0 while stalled, out_data held at 0x00000001. After release, outputs are 0x1, 0x2, 0x4, 0x8 in order, with no loss or duplication.
- Throughput: 16 consecutive random beats with out_ready=1 -> 16 results on 16 consecutive cycles, each matching the reference model. Repeat with STAGES=1 and STAGES=5 for latency 1 and 5.

Source files
------------

// File: rtl/shift_unit_pipe_if.sv
// Valid/ready bus for the pipelined barrel shifter.
// The master drives operands and out_ready; the slave returns the result.
interface shift_unit_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTR) with one global advance signal.
// Each stage applies its own slice of the shift amount to the previous stage's result.
module shift_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  shift_unit_pipe_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int BPS = (SHW + STAGES - 1) / STAGES;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  // Shift-amount bits handled by stage s, kept at their weighted position.
  function automatic logic [SHW-1:0] slice_mask(input int s);
    logic [SHW-1:0] m;
    m = '0;
    for (int i = 0; i < SHW; i++) begin
      m[i] = (i >= s * BPS) && (i < (s + 1) * BPS);
    end
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] shift_f(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   amt,
    input op_e              op,
    input logic             sign
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill;
    logic [SHW:0]     lamt;
    fill = ~({WIDTH{1'b1}} >> amt);
    lamt = (SHW + 1)'(WIDTH) - {1'b0, amt};
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = (d >> amt) | (sign ? fill : '0);
      default: r = (d >> amt) | (d << lamt);
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]  data_q   [STAGES];
  logic [SHW-1:0]    shamt_q  [STAGES];
  op_e               op_q     [STAGES];
  logic [STAGES-1:0] sign_q;
  logic [STAGES-1:0] valid_q;

  logic [WIDTH-1:0]  data_d    [STAGES];
  logic [WIDTH-1:0]  src_data  [STAGES];
  logic [SHW-1:0]    src_shamt [STAGES];
  op_e               src_op    [STAGES];
  logic [STAGES-1:0] src_sign;
  logic [STAGES-1:0] src_valid;
  logic              advance;

  assign advance       = bus.out_ready | ~valid_q[STAGES-1];
  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];

  // The original MSB travels with each beat so SRA fills correctly in every stage.
  always_comb begin
    src_data[0]  = bus.in_data;
    src_shamt[0] = bus.in_shamt;
    src_op[0]    = op_e'(bus.in_op);
    src_sign[0]  = bus.in_data[WIDTH-1];
    src_valid[0] = bus.in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_data[s]  = data_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_sign[s]  = sign_q[s-1];
      src_valid[s] = valid_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      data_d[s] = shift_f(src_data[s], src_shamt[s] & slice_mask(s), src_op[s], src_sign[s]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= OP_SLL;
      end
    end else if (advance) begin
      valid_q <= src_valid;
      sign_q  <= src_sign;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s]  <= data_d[s];
        shamt_q[s] <= src_shamt[s];
        op_q[s]    <= src_op[s];
      end
    end
  end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: main checks on STAGES=2, latency/throughput
// also exercised on STAGES=1 and STAGES=5 instances fed with the same stimulus.
module tb_shift_unit_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_unit_pipe_if #(.WIDTH(32)) bus1 ();
  shift_unit_pipe_if #(.WIDTH(32)) bus2 ();
  shift_unit_pipe_if #(.WIDTH(32)) bus5 ();

  shift_unit_pipe #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  shift_unit_pipe #(.WIDTH(32), .STAGES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  shift_unit_pipe #(.WIDTH(32), .STAGES(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROTR = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bd [16];
  logic [4:0]  bs [16];
  logic [1:0]  bo [16];
  logic [31:0] be [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op);
    bus1.in_valid = v; bus1.in_data = d; bus1.in_shamt = sh; bus1.in_op = op;
    bus2.in_valid = v; bus2.in_data = d; bus2.in_shamt = sh; bus2.in_op = op;
    bus5.in_valid = v; bus5.in_data = d; bus5.in_shamt = sh; bus5.in_op = op;
  endtask

  task automatic set_ready(input logic r);
    bus1.out_ready = r;
    bus2.out_ready = r;
    bus5.out_ready = r;
  endtask

  // Bit-by-bit reference: each result bit picks its source bit directly.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] op);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (op)
        SLL:     r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        SRL:     r[i] = (i + sh < 32) ? d[i+sh] : 1'b0;
        SRA:     r[i] = (i + sh < 32) ? d[i+sh] : d[31];
        default: r[i] = d[(i + sh) % 32];
      endcase
    end
    return r;
  endfunction

  // Single isolated beat on the STAGES=2 instance: silent after the accepting edge, result one edge later.
  task automatic send_chk(input string tag, input logic [31:0] d, input logic [4:0] sh,
                          input logic [1:0] op, input logic [31:0] exp);
    @(negedge clk); drive(1'b1, d, sh, op);
    @(posedge clk); #1;
    chk({tag, "_early_valid"}, {31'b0, bus2.out_valid}, 32'd0);
    @(negedge clk); drive(1'b0, 32'd0, 5'd0, SLL);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'b0, bus2.out_valid}, 32'd1);
    chk({tag, "_data"}, bus2.out_data, exp);
  endtask

  task automatic chk_lat(input string tag, input int lat, input int c,
                         input logic ov, input logic [31:0] od);
    int  k;
    logic ev;
    k  = c - (lat - 1);
    ev = (k >= 0) && (k < 16);
    chk({tag, "_valid"}, {31'b0, ov}, {31'b0, ev});
    if (ev) chk({tag, "_data"}, od, be[k]);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 5'd0, SLL);
    set_ready(1'b1);
    #2;
    chk("rst_out_valid", {31'b0, bus2.out_valid}, 32'd0);
    chk("rst_out_data", bus2.out_data, 32'h0000_0000);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, bus2.in_ready}, 32'd1);

    send_chk("off_sll2", 32'hFFFF_FFFF, 5'd2, SLL, 32'hFFFF_FFFC);
    send_chk("sll31", 32'h0000_0001, 5'd31, SLL, 32'h8000_0000);
    send_chk("srl31", 32'h8000_0000, 5'd31, SRL, 32'h0000_0001);
    send_chk("sra31", 32'h8000_0000, 5'd31, SRA, 32'hFFFF_FFFF);
    send_chk("sra4_pos", 32'h7FFF_FFF0, 5'd4, SRA, 32'h07FF_FFFF);
    send_chk("rotr8", 32'h1234_5678, 5'd8, ROTR, 32'h7812_3456);
    send_chk("rotr0", 32'h1234_5678, 5'd0, ROTR, 32'h1234_5678);
    send_chk("sll0", 32'h1234_5678, 5'd0, SLL, 32'h1234_5678);
    send_chk("sra0_neg", 32'h8000_0001, 5'd0, SRA, 32'h8000_0001);
    send_chk("rotr1", 32'h0000_0001, 5'd1, ROTR, 32'h8000_0000);
    send_chk("sra13", 32'hF000_0000, 5'd13, SRA, 32'hFFFF_8000);

    // Backpressure: four beats SLL 1 by 0..3, out_ready low for three edges.
    @(negedge clk); drive(1'b1, 32'd1, 5'd0, SLL);
    @(posedge clk); #1;
    @(negedge clk); drive(1'b1, 32'd1, 5'd1, SLL); set_ready(1'b0);
    @(posedge clk); #1;
    chk("bp_valid_e2", {31'b0, bus2.out_valid}, 32'd1);
    chk("bp_data_e2", bus2.out_data, 32'h1);
    chk("bp_ready_e2", {31'b0, bus2.in_ready}, 32'd0);
    @(negedge clk); drive(1'b1, 32'd1, 5'd2, SLL);
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'b0, bus2.out_valid}, 32'd1);
      chk("bp_hold_data", bus2.out_data, 32'h1);
      chk("bp_hold_ready", {31'b0, bus2.in_ready}, 32'd0);
    end
    @(negedge clk); set_ready(1'b1);
    #1;
    chk("bp_release_ready", {31'b0, bus2.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp_out1_valid", {31'b0, bus2.out_valid}, 32'd1);
    chk("bp_out1_data", bus2.out_data, 32'h2);
    @(negedge clk); drive(1'b1, 32'd1, 5'd3, SLL);
    @(posedge clk); #1;
    chk("bp_out2_data", bus2.out_data, 32'h4);
    @(negedge clk); drive(1'b0, 32'd0, 5'd0, SLL);
    @(posedge clk); #1;
    chk("bp_out3_valid", {31'b0, bus2.out_valid}, 32'd1);
    chk("bp_out3_data", bus2.out_data, 32'h8);
    @(posedge clk); #1;
    chk("bp_drained", {31'b0, bus2.out_valid}, 32'd0);

    // Asynchronous reset with a beat at the output.
    @(negedge clk); drive(1'b1, 32'hA5A5_A5A5, 5'd4, SRL);
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_pre_valid", {31'b0, bus2.out_valid}, 32'd1);
    chk("mid_pre_data", bus2.out_data, 32'h0A5A_5A5A);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, bus2.out_valid}, 32'd0);
    chk("mid_rst_data", bus2.out_data, 32'h0000_0000);
    chk("mid_rst_valid_s5", {31'b0, bus5.out_valid}, 32'd0);
    @(negedge clk); reset = 1'b0; drive(1'b0, 32'd0, 5'd0, SLL);
    #1;
    chk("mid_in_ready", {31'b0, bus2.in_ready}, 32'd1);

    // Throughput: 16 back-to-back random beats into all three depths.
    for (int i = 0; i < 16; i++) begin
      bd[i] = $urandom;
      bs[i] = 5'($urandom_range(0, 31));
      bo[i] = 2'($urandom_range(0, 3));
      be[i] = ref_shift(bd[i], int'(bs[i]), bo[i]);
    end
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c < 16) drive(1'b1, bd[c], bs[c], bo[c]);
      else        drive(1'b0, 32'd0, 5'd0, SLL);
      @(posedge clk); #1;
      chk_lat("tp_s1", 1, c, bus1.out_valid, bus1.out_data);
      chk_lat("tp_s2", 2, c, bus2.out_valid, bus2.out_data);
      chk_lat("tp_s5", 5, c, bus5.out_valid, bus5.out_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
